float2fix_pipe: RTL and testbench

//  Pipelined, handshaked IEEE-754 float to signed fixed-point converter.

---
 rtl/float2fix_pipe.sv | 203 ++++++++++++++++++++
 tb/tb_float2fix_pipe.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/float2fix_pipe.sv
// Three-stage handshaked IEEE-754 float to signed fixed-point converter with
// selectable RTZ/RNE rounding, signed saturation and per-result exception flags.
module float2fix_pipe #(
  parameter int unsigned EXP_W  = 8,
  parameter int unsigned MAN_W  = 23,
  parameter int unsigned INT_W  = 32,
  parameter int unsigned FRAC_W = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic [EXP_W+MAN_W:0]    float_i,
  input  logic                    rnd_mode_i,
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic [INT_W+FRAC_W-1:0] fix_o,
  output logic [3:0]              flags_o
);

  localparam int unsigned OUT_W  = INT_W + FRAC_W;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned MAG_W  = OUT_W + 1;
  localparam int unsigned EXT_W  = 2 * SIG_W;
  localparam int          BIAS   = (1 << (EXP_W - 1)) - 1;
  // Left-shift amount of the significand onto the FRAC_W grid is exp + SH_OFS.
  localparam int          SH_OFS = int'(FRAC_W) - int'(MAN_W) - BIAS;
  localparam int          SH_BIG = int'(OUT_W) - int'(MAN_W);

  localparam logic [MAG_W:0]   NEG_LIM = {2'b00, 1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [MAG_W:0]   POS_LIM = NEG_LIM - 1'b1;
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [2:0] {ClsZero, ClsDenorm, ClsNormal, ClsInf, ClsNan} cls_e;

  logic adv;
  logic out_valid_q;
  logic [OUT_W-1:0] fix_q;
  logic [3:0] flags_q;

  assign adv         = !out_valid_q | out_ready_i;
  assign in_ready_o  = adv;
  assign out_valid_o = out_valid_q;
  assign fix_o       = fix_q;
  assign flags_o     = flags_q;

  // S1: unpack and classify
  logic             in_sign;
  logic [EXP_W-1:0] in_exp;
  logic [MAN_W-1:0] in_man;
  cls_e             in_cls;

  assign {in_sign, in_exp, in_man} = float_i;

  always_comb begin
    if (in_exp == '0) begin
      in_cls = (in_man == '0) ? ClsZero : ClsDenorm;
    end else if (&in_exp) begin
      in_cls = (in_man == '0) ? ClsInf : ClsNan;
    end else begin
      in_cls = ClsNormal;
    end
  end

  logic             s1_valid_q;
  logic             s1_sign_q;
  logic             s1_rnd_q;
  cls_e             s1_cls_q;
  logic [SIG_W-1:0] s1_sig_q;
  int               s1_sh_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_rnd_q   <= 1'b0;
      s1_cls_q   <= ClsZero;
      s1_sig_q   <= '0;
      s1_sh_q    <= 0;
    end else if (adv) begin
      s1_valid_q <= in_valid_i;
      s1_sign_q  <= in_sign;
      s1_rnd_q   <= rnd_mode_i;
      s1_cls_q   <= in_cls;
      s1_sig_q   <= {1'b1, in_man};
      s1_sh_q    <= int'(in_exp) + SH_OFS;
    end
  end

  // S2: align magnitude, keep guard and sticky
  logic [MAG_W-1:0] sh_mag;
  logic             sh_guard;
  logic             sh_sticky;
  logic             sh_big;
  logic [EXT_W-1:0] ext;
  int unsigned      rsh;

  always_comb begin
    sh_mag    = '0;
    sh_guard  = 1'b0;
    sh_sticky = 1'b0;
    sh_big    = 1'b0;
    ext       = '0;
    rsh       = '0;
    if (s1_sh_q >= 0) begin
      if (s1_sh_q >= SH_BIG) begin
        sh_big = 1'b1;
      end else begin
        sh_mag = {{(MAG_W-SIG_W){1'b0}}, s1_sig_q} << s1_sh_q;
      end
    end else begin
      rsh = unsigned'(-s1_sh_q);
      // Beyond one full significand width only a sticky bit survives.
      if (rsh > SIG_W) begin
        sh_sticky = 1'b1;
      end else begin
        ext       = {s1_sig_q, {SIG_W{1'b0}}} >> rsh;
        sh_mag    = {{(MAG_W-SIG_W){1'b0}}, ext[EXT_W-1:SIG_W]};
        sh_guard  = ext[SIG_W-1];
        sh_sticky = |ext[SIG_W-2:0];
      end
    end
  end

  logic             s2_valid_q;
  logic             s2_sign_q;
  logic             s2_rnd_q;
  cls_e             s2_cls_q;
  logic [MAG_W-1:0] s2_mag_q;
  logic             s2_guard_q;
  logic             s2_sticky_q;
  logic             s2_big_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_rnd_q    <= 1'b0;
      s2_cls_q    <= ClsZero;
      s2_mag_q    <= '0;
      s2_guard_q  <= 1'b0;
      s2_sticky_q <= 1'b0;
      s2_big_q    <= 1'b0;
    end else if (adv) begin
      s2_valid_q  <= s1_valid_q;
      s2_sign_q   <= s1_sign_q;
      s2_rnd_q    <= s1_rnd_q;
      s2_cls_q    <= s1_cls_q;
      s2_mag_q    <= sh_mag;
      s2_guard_q  <= sh_guard;
      s2_sticky_q <= sh_sticky;
      s2_big_q    <= sh_big;
    end
  end

  // S3: round magnitude, negate, saturate, flag
  logic             rnd_inc;
  logic [MAG_W:0]   rnd_mag;
  logic             ovf;
  logic [OUT_W-1:0] res_fix;
  logic [3:0]       res_flags;

  always_comb begin
    rnd_inc   = s2_rnd_q & s2_guard_q & (s2_sticky_q | s2_mag_q[0]);
    rnd_mag   = {1'b0, s2_mag_q} + {{MAG_W{1'b0}}, rnd_inc};
    ovf       = s2_big_q | (s2_sign_q ? (rnd_mag > NEG_LIM) : (rnd_mag > POS_LIM));
    res_fix   = '0;
    res_flags = '0;
    unique case (s2_cls_q)
      ClsZero:   res_flags = 4'b0000;
      ClsDenorm: res_flags = 4'b0011;
      ClsNan:    res_flags = 4'b1000;
      ClsInf: begin
        res_fix   = s2_sign_q ? SAT_NEG : SAT_POS;
        res_flags = 4'b0100;
      end
      ClsNormal: begin
        if (ovf) begin
          res_fix   = s2_sign_q ? SAT_NEG : SAT_POS;
          res_flags = 4'b0100;
        end else begin
          res_fix   = s2_sign_q ? -rnd_mag[OUT_W-1:0] : rnd_mag[OUT_W-1:0];
          res_flags = {2'b00, rnd_mag == '0, s2_guard_q | s2_sticky_q};
        end
      end
      default: res_flags = 4'b0000;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid_q <= 1'b0;
      fix_q       <= '0;
      flags_q     <= '0;
    end else if (adv) begin
      out_valid_q <= s2_valid_q;
      fix_q       <= res_fix;
      flags_q     <= res_flags;
    end
  end

endmodule

// File: tb/tb_float2fix_pipe.sv
// Directed bench for float2fix_pipe: vector table with latency checks, plus
// backpressure and mid-stream reset sequences.
module tb_float2fix_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] flt;
  logic        rnd;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] fix;
  logic [3:0]  flags;

  int n_run  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [31:0] f;
    logic        rnd;
    logic [63:0] fix;
    logic [3:0]  flags;
  } vec_t;

  localparam int NV = 25;
  vec_t vecs [NV];
  vec_t bp [6];

  float2fix_pipe dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .float_i    (flt),
    .rnd_mode_i (rnd),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .fix_o      (fix),
    .flags_o    (flags)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Single operand, out_ready high: result must appear exactly 3 edges after acceptance.
  task automatic run_vec(input vec_t v, input string name);
    logic early;
    flt      = v.f;
    rnd      = v.rnd;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    early = out_valid;
    @(posedge clk); #1;
    check({name, "_lat"}, {70'd0, early, out_valid}, 72'b01);
    check(name, {4'd0, fix, flags}, {4'd0, v.fix, v.flags});
    @(posedge clk); #1;
  endtask

  initial begin
    int sent;
    int recv;
    int seen;
    logic prev_stall;
    logic [63:0] prev_fix;
    logic [3:0] prev_flags;

    vecs[0]  = '{32'h3F80_0000, 1'b0, 64'h0000_0001_0000_0000, 4'b0000};
    vecs[1]  = '{32'hC020_0000, 1'b0, 64'hFFFF_FFFD_8000_0000, 4'b0000};
    vecs[2]  = '{32'hCF00_0000, 1'b0, 64'h8000_0000_0000_0000, 4'b0000};
    vecs[3]  = '{32'h4F00_0000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0100};
    vecs[4]  = '{32'hFF80_0000, 1'b0, 64'h8000_0000_0000_0000, 4'b0100};
    vecs[5]  = '{32'h7FC0_0000, 1'b0, 64'h0,                   4'b1000};
    vecs[6]  = '{32'h2F00_0000, 1'b1, 64'h0,                   4'b0011};
    vecs[7]  = '{32'h2F40_0000, 1'b1, 64'h1,                   4'b0001};
    vecs[8]  = '{32'h2F40_0000, 1'b0, 64'h0,                   4'b0011};
    vecs[9]  = '{32'h0000_0000, 1'b0, 64'h0,                   4'b0000};
    vecs[10] = '{32'h8000_0000, 1'b1, 64'h0,                   4'b0000};
    vecs[11] = '{32'h0000_0001, 1'b1, 64'h0,                   4'b0011};
    vecs[12] = '{32'h7F80_0000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0100};
    vecs[13] = '{32'h3F00_0000, 1'b0, 64'h0000_0000_8000_0000, 4'b0000};
    vecs[14] = '{32'hBF80_0000, 1'b1, 64'hFFFF_FFFF_0000_0000, 4'b0000};
    vecs[15] = '{32'h7F00_0000, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0100};
    vecs[16] = '{32'h0080_0000, 1'b1, 64'h0,                   4'b0011};
    vecs[17] = '{32'hAF40_0000, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0001};
    vecs[18] = '{32'h2FC0_0000, 1'b1, 64'h2,                   4'b0001};
    vecs[19] = '{32'h2FC0_0000, 1'b0, 64'h1,                   4'b0001};
    vecs[20] = '{32'h4EFF_FFFF, 1'b0, 64'h7FFF_FF80_0000_0000, 4'b0000};
    vecs[21] = '{32'hCF00_0001, 1'b0, 64'h8000_0000_0000_0000, 4'b0100};
    vecs[22] = '{32'hFFC0_0001, 1'b1, 64'h0,                   4'b1000};
    vecs[23] = '{32'hAF40_0000, 1'b0, 64'h0,                   4'b0011};
    vecs[24] = '{32'h3EAA_AAAB, 1'b0, 64'h0000_0000_5555_5580, 4'b0000};

    bp[0] = '{32'h3F80_0000, 1'b0, 64'h0000_0001_0000_0000, 4'b0000};
    bp[1] = '{32'h2F40_0000, 1'b1, 64'h1,                   4'b0001};
    bp[2] = '{32'h2F40_0000, 1'b0, 64'h0,                   4'b0011};
    bp[3] = '{32'hC020_0000, 1'b0, 64'hFFFF_FFFD_8000_0000, 4'b0000};
    bp[4] = '{32'h7FC0_0000, 1'b0, 64'h0,                   4'b1000};
    bp[5] = '{32'h4F00_0000, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0100};

    rst       = 1'b1;
    in_valid  = 1'b0;
    flt       = '0;
    rnd       = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("reset_state", {2'd0, in_ready, out_valid, fix, flags}, {2'd0, 1'b1, 1'b0, 64'h0, 4'h0});

    for (int i = 0; i < NV; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Back-to-back stream with a 4-cycle consumer stall.
    sent       = 0;
    recv       = 0;
    prev_stall = 1'b0;
    prev_fix   = '0;
    prev_flags = '0;
    for (int cyc = 0; cyc < 60 && recv < 6; cyc++) begin
      out_ready = !(cyc >= 5 && cyc <= 8);
      in_valid  = (sent < 6);
      flt       = bp[(sent < 6) ? sent : 0].f;
      rnd       = bp[(sent < 6) ? sent : 0].rnd;
      #1;
      if (prev_stall) begin
        check($sformatf("bp_hold_c%0d", cyc), {3'd0, out_valid, fix, flags},
              {3'd0, 1'b1, prev_fix, prev_flags});
      end
      if (out_valid && !out_ready) begin
        check($sformatf("bp_stall_rdy_c%0d", cyc), {71'd0, in_ready}, 72'd0);
      end
      if (out_valid && out_ready) begin
        check($sformatf("bp_res%0d", recv), {4'd0, fix, flags},
              {4'd0, bp[recv].fix, bp[recv].flags});
        recv++;
      end
      if (in_valid && in_ready) sent++;
      prev_stall = out_valid && !out_ready;
      prev_fix   = fix;
      prev_flags = flags;
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("bp_count", {40'd0, sent[15:0], recv[15:0]}, {40'd0, 16'd6, 16'd6});
    seen = 0;
    repeat (4) begin
      #1;
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("bp_no_dup", {40'd0, seen}, 72'd0);

    // Three operands in flight, then reset: none may ever be delivered.
    out_ready = 1'b0;
    for (int k = 3; k < 6; k++) begin
      flt      = vecs[k].f;
      rnd      = vecs[k].rnd;
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst      = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_clear", {6'd0, out_valid, fix, flags}, 72'd0);
    out_ready = 1'b1;
    seen = 0;
    repeat (5) begin
      #1;
      if (out_valid) seen++;
      @(posedge clk); #1;
    end
    check("rst_no_emerge", {40'd0, seen}, 72'd0);
    run_vec(vecs[1], "rst_after");

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
